// File: rtl/ide_host_pio_reader.sv
// IDE host-side PIO initiator: writes an LBA28 READ SECTORS task file,
// polls status until DRQ, then streams 256 data words out one per strobe.
module ide_host_pio_reader #(
    parameter int unsigned T_SETUP        = 2,
    parameter int unsigned T_PULSE        = 8,
    parameter int unsigned T_HOLD         = 7,
    parameter int unsigned TIMEOUT_CYCLES = 27000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [27:0] lba,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] word_out,
    output logic        word_valid,
    output logic [7:0]  word_index,
    output logic        cs0_n,
    output logic        dior_n,
    output logic        diow_n,
    output logic [2:0]  addr,
    output logic [15:0] data_out,
    output logic        data_oe,
    input  logic [15:0] data_in
);

    typedef enum logic [3:0] {
        IDLE, TF_SETUP, TF_PULSE, TF_HOLD,
        POLL_SETUP, POLL_PULSE, POLL_HOLD, POLL_EVAL,
        DATA_SETUP, DATA_PULSE, DATA_HOLD, FINISH, FAIL
    } state_t;

    // Phase counter covers SETUP, PULSE and HOLD plus the trailing cs0_n-high gap cycle.
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(T_PULSE - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_CNT    = CNT_W'(T_HOLD);
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [TO_W-1:0]   to_q;
    logic [2:0]        reg_idx_q;
    logic [8:0]        word_cnt_q;
    logic [27:0]       lba_q;
    logic              sts_bsy_q, sts_drq_q, sts_err_q;
    logic              cs0_n_q, dior_n_q, diow_n_q, data_oe_q;
    logic [2:0]        addr_q;
    logic [15:0]       data_out_q, word_out_q;
    logic              busy_q, done_q, error_q, word_valid_q;
    logic [7:0]        word_index_q;
    logic              in_poll;

    // Task-file register address for write index 0..5 (device regs 2..7).
    function automatic logic [2:0] tf_addr(input logic [2:0] idx);
        return idx + 3'd2;
    endfunction

    // Task-file register value: sector count, LBA bytes, LBA-mode drive/head, command.
    function automatic logic [7:0] tf_val(input logic [2:0] idx, input logic [27:0] a);
        case (idx)
            3'd0:    return 8'h01;
            3'd1:    return a[7:0];
            3'd2:    return a[15:8];
            3'd3:    return a[23:16];
            3'd4:    return {4'hE, a[27:24]};
            default: return 8'h20;
        endcase
    endfunction

    assign in_poll = (state_q == POLL_SETUP) || (state_q == POLL_PULSE) ||
                     (state_q == POLL_HOLD)  || (state_q == POLL_EVAL);

    // Sequencer: every bus pin and status output is registered here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            to_q         <= '0;
            reg_idx_q    <= '0;
            word_cnt_q   <= '0;
            lba_q        <= '0;
            sts_bsy_q    <= 1'b0;
            sts_drq_q    <= 1'b0;
            sts_err_q    <= 1'b0;
            cs0_n_q      <= 1'b1;
            dior_n_q     <= 1'b1;
            diow_n_q     <= 1'b1;
            addr_q       <= '0;
            data_out_q   <= '0;
            data_oe_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            word_out_q   <= '0;
            word_valid_q <= 1'b0;
            word_index_q <= '0;
        end else begin
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            word_valid_q <= 1'b0;
            if (in_poll && (to_q == TO_LAST)) begin
                // Timeout wins over any status evaluation in the same cycle.
                state_q  <= FAIL;
                error_q  <= 1'b1;
                busy_q   <= 1'b0;
                cs0_n_q  <= 1'b1;
                dior_n_q <= 1'b1;
                cnt_q    <= '0;
            end else begin
                if (in_poll) to_q <= to_q + TO_W'(1);
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            lba_q      <= lba;
                            busy_q     <= 1'b1;
                            reg_idx_q  <= '0;
                            cnt_q      <= '0;
                            cs0_n_q    <= 1'b0;
                            addr_q     <= tf_addr(3'd0);
                            data_out_q <= {8'h00, tf_val(3'd0, lba)};
                            data_oe_q  <= 1'b1;
                            state_q    <= TF_SETUP;
                        end
                    end
                    TF_SETUP, POLL_SETUP, DATA_SETUP: begin
                        if (cnt_q == SETUP_LAST) begin
                            cnt_q <= '0;
                            if (state_q == TF_SETUP) begin
                                diow_n_q <= 1'b0;
                                state_q  <= TF_PULSE;
                            end else begin
                                dior_n_q <= 1'b0;
                                state_q  <= (state_q == POLL_SETUP) ? POLL_PULSE : DATA_PULSE;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    TF_PULSE, POLL_PULSE, DATA_PULSE: begin
                        if (cnt_q == PULSE_LAST) begin
                            cnt_q <= '0;
                            if (state_q == TF_PULSE) begin
                                diow_n_q <= 1'b1;
                                state_q  <= TF_HOLD;
                            end else if (state_q == POLL_PULSE) begin
                                dior_n_q  <= 1'b1;
                                sts_bsy_q <= data_in[7];
                                sts_drq_q <= data_in[3];
                                sts_err_q <= data_in[0];
                                state_q   <= POLL_HOLD;
                            end else begin
                                dior_n_q     <= 1'b1;
                                word_out_q   <= data_in;
                                word_index_q <= word_cnt_q[7:0];
                                word_valid_q <= 1'b1;
                                word_cnt_q   <= word_cnt_q + 9'd1;
                                state_q      <= DATA_HOLD;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    TF_HOLD, POLL_HOLD, DATA_HOLD: begin
                        if (cnt_q == HOLD_LAST) begin
                            // Last hold cycle done: release chip select for the gap cycle.
                            cs0_n_q   <= 1'b1;
                            data_oe_q <= 1'b0;
                            cnt_q     <= cnt_q + CNT_W'(1);
                        end else if (cnt_q == GAP_CNT) begin
                            cnt_q <= '0;
                            if (state_q == TF_HOLD) begin
                                if (reg_idx_q == 3'd5) begin
                                    to_q    <= '0;
                                    cs0_n_q <= 1'b0;
                                    addr_q  <= 3'd7;
                                    state_q <= POLL_SETUP;
                                end else begin
                                    reg_idx_q  <= reg_idx_q + 3'd1;
                                    cs0_n_q    <= 1'b0;
                                    addr_q     <= tf_addr(reg_idx_q + 3'd1);
                                    data_out_q <= {8'h00, tf_val(reg_idx_q + 3'd1, lba_q)};
                                    data_oe_q  <= 1'b1;
                                    state_q    <= TF_SETUP;
                                end
                            end else if (state_q == POLL_HOLD) begin
                                state_q <= POLL_EVAL;
                            end else if (word_cnt_q == 9'd256) begin
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                state_q <= FINISH;
                            end else begin
                                cs0_n_q <= 1'b0;
                                addr_q  <= 3'd0;
                                state_q <= DATA_SETUP;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    POLL_EVAL: begin
                        if (!sts_bsy_q && sts_err_q) begin
                            error_q <= 1'b1;
                            busy_q  <= 1'b0;
                            cs0_n_q <= 1'b1;
                            state_q <= FAIL;
                        end else if (!sts_bsy_q && sts_drq_q) begin
                            word_cnt_q <= '0;
                            cs0_n_q    <= 1'b0;
                            addr_q     <= 3'd0;
                            state_q    <= DATA_SETUP;
                        end else begin
                            cs0_n_q <= 1'b0;
                            addr_q  <= 3'd7;
                            state_q <= POLL_SETUP;
                        end
                    end
                    FINISH:  state_q <= IDLE;
                    FAIL:    state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign word_out   = word_out_q;
    assign word_valid = word_valid_q;
    assign word_index = word_index_q;
    assign cs0_n      = cs0_n_q;
    assign dior_n     = dior_n_q;
    assign diow_n     = diow_n_q;
    assign addr       = addr_q;
    assign data_out   = data_out_q;
    assign data_oe    = data_oe_q;

endmodule

// File: doc/ide_host_pio_reader.md
Name: ide_host_pio_reader

Overview:
- IDE host-side initiator: the counterpart of the board's IDE device block. It drives cs0_n/dior_n/diow_n/addr toward an IDE target and issues a single-sector READ SECTORS command (0x20, LBA28).
- It polls status until data is ready, then reads 256 PIO words and streams them out one word per strobe.
- Used as a bench/bring-up host to exercise the IDE device and SD path on-board without the CNC.

Parameters:
- T_SETUP, 2: cycles that addr/cs0_n (and write data) are stable before the strobe falls.
- T_PULSE, 8: cycles the strobe (dior_n/diow_n) is held low.
- T_HOLD, 7: cycles after the strobe rises before the next transaction. The default total of 17 cycles at 27 MHz is 629 ns, which meets the PIO0 600 ns cycle.
- TIMEOUT_CYCLES, 27000000: cycles allowed from the command write until DRQ is seen (1 s at 27 MHz).

Ports:
- clk  in  1  system clock (27 MHz OSC)
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to read one sector
- lba  in  28  sector address, sampled when start is accepted
- busy  out  1  high from start acceptance until done/error
- done  out  1  one-cycle pulse after the 256th word
- error  out  1  one-cycle pulse on device ERR or timeout
- word_out  out  16  data word read from the data register
- word_valid  out  1  one-cycle qualifier for word_out
- word_index  out  8  index 0..255 of the current word_out
- cs0_n  out  1  IDE chip select, active low
- dior_n  out  1  IDE read strobe, active low
- diow_n  out  1  IDE write strobe, active low
- addr  out  3  IDE register address
- data_out  out  16  host write data
- data_oe  out  1  tristate enable for data_out; the bus driver lives outside this block
- data_in  in  16  IDE data bus as seen by the host

Behaviour:
- Reset (async, reset_n low) values: cs0_n=1, dior_n=1, diow_n=1, addr=0, data_out=0, data_oe=0, busy=0, done=0, error=0, word_valid=0, word_out=0, word_index=0. All counters clear and the FSM goes to IDLE.
- Reset asserted mid-operation aborts immediately to these values. No done or error pulse is generated.
- Every bus transaction has three phases:
  - SETUP: T_SETUP cycles, cs0_n=0 and addr valid.
  - PULSE: T_PULSE cycles, strobe low.
  - HOLD: T_HOLD cycles, strobe high and cs0_n=0.
  - cs0_n returns to 1 for one cycle between transactions.
- Reads sample data_in on the last PULSE cycle, i.e. the cycle before dior_n rises.
- Writes drive data_oe=1 for the whole SETUP+PULSE+HOLD window, with data_out = {8'h00, reg value}.
- data_oe is never 1 while dior_n=0.
- FSM states: IDLE, TF_SETUP, TF_PULSE, TF_HOLD, POLL_SETUP, POLL_PULSE, POLL_HOLD, POLL_EVAL, DATA_SETUP, DATA_PULSE, DATA_HOLD, FINISH, FAIL.
- IDLE: when start=1, latch lba, set busy=1, set reg index=0, go to TF_SETUP. A start while busy=1 is ignored.
- Task-file write sequence, by reg index 0..5 (address / value):
  - 0: addr 2 / 0x01
  - 1: addr 3 / lba[7:0]
  - 2: addr 4 / lba[15:8]
  - 3: addr 5 / lba[23:16]
  - 4: addr 6 / 0xE0|lba[27:24]
  - 5: addr 7 / 0x20
- After index 5 completes HOLD, clear the timeout counter and go to POLL_SETUP.
- Poll reads addr 7. POLL_EVAL takes one cycle on the captured status:
  - BSY (bit7)=1: repoll.
  - BSY=0 and ERR (bit0)=1: go to FAIL.
  - BSY=0 and DRQ (bit3)=1: go to DATA_SETUP with word count=0.
  - Otherwise: repoll.
- Timeout counter: increments every cycle in POLL_* states. If it reaches TIMEOUT_CYCLES-1, go to FAIL, with priority over POLL_EVAL in the same cycle.
- Data phase reads addr 0. On the sample cycle: word_out=data_in, word_index=count, word_valid=1 for exactly that cycle, then count increments.
- After count 255, HOLD completes and the FSM goes to FINISH. Count is 9 bits internally, so no wrap occurs before exit.
- DRQ is not re-checked between words; a single sector is 256 back-to-back transactions.
- FINISH: done=1 for one cycle, busy=0, go to IDLE.
- FAIL: error=1 for one cycle, busy=0, cs0_n=1, go to IDLE.
- start on the same cycle as a done/error pulse is ignored; it is accepted from the next cycle onward.
- Latency with default timing and one poll: 6×18 + 18 + 1 + 256×18 cycles, ±1 cycle for the FINISH state.

Test Plan:
- Basic read: start with lba=0x0123456 to a device model answering status 0x58 and words 0x0000..0x00FF. Required response:
  - Writes 01, 56, 34, 12, E0, 20 appear at addrs 2..7.
  - 256 word_valid pulses arrive with word_out equal to word_index.
  - done pulses once and busy falls.
- Busy wait: the device returns 0x80 for 5 polls, then 0x58. Required: exactly 6 reads of addr 7 and no early data reads. The word stream matches the device model's data.
- Device error: status 0x51 after the command. Required: error pulses once, there are no word_valid pulses, done stays 0, and busy falls.
- Timeout: TIMEOUT_CYCLES=200 and status stuck at 0x80. Required: error pulses about 200 cycles after the command write, with cs0_n=1 afterwards.
- Start while busy: a second start with a different lba during the data phase is ignored. The task-file writes still carry the first lba, and only one done is produced.
- Reset mid-data: reset_n is pulled low at word 100. Required: all outputs take their reset values asynchronously. There is no done or error. A fresh start then completes a full 256-word read.
- Throughout every scenario, an assertion checks that data_oe is never 1 while dior_n is 0.
